rf_write_arbiter: RTL and testbench

- Owns the single register-file write port (RW/PW/LE). Shares it between the pipeline write-back stage and the multi-cycle unit (mult/div/load-miss).
- Holds a 32-entry pending-write scoreboard that stalls issue on RAW/WAW hazards against outstanding long-latency destinations.
- Sits between WB/multi-cycle unit and the register file. Its stall outputs go to hazard control.

---
 rtl/rf_write_arbiter_if.sv | 44 ++++
 rtl/rf_write_arbiter.sv | 117 +++++++++++
 tb/tb_rf_write_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Signal bundle between the WB stage, multi-cycle unit, issue stage and the
// register-file write arbiter. The arbiter takes the slave side.
interface rf_write_arbiter_if;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        mc_ready;

    logic [4:0]  iss_ra;
    logic [4:0]  iss_rb;
    logic [4:0]  iss_rd;
    logic        iss_ra_use;
    logic        iss_rb_use;
    logic        iss_rd_use;
    logic        iss_long;
    logic        iss_valid;
    logic        issue_stall;
    logic        pipe_stall;

    logic [4:0]  RW;
    logic [31:0] PW;
    logic        LE;
    logic [31:0] pend;

    modport master (
        output wb_valid, wb_rd, wb_data,
        output mc_valid, mc_rd, mc_data,
        output iss_ra, iss_rb, iss_rd, iss_ra_use, iss_rb_use, iss_rd_use,
        output iss_long, iss_valid,
        input  mc_ready, issue_stall, pipe_stall, RW, PW, LE, pend
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data,
        input  mc_valid, mc_rd, mc_data,
        input  iss_ra, iss_rb, iss_rd, iss_ra_use, iss_rb_use, iss_rd_use,
        input  iss_long, iss_valid,
        output mc_ready, issue_stall, pipe_stall, RW, PW, LE, pend
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter (WB over multi-cycle) with a pending-write
// scoreboard and starvation guard. Define RF_ARB_PERF_EN for conflict_cnt.
module rf_write_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int PERF_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rf_write_arbiter_if.slave    bus
`ifdef RF_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0]    conflict_cnt
`endif
);

    typedef enum logic {ARB, FORCE} state_t;

    localparam logic [4:0] LIMIT = 5'(STARVE_LIMIT);

    state_t      state_q, state_nxt;
    logic [4:0]  rw_q;
    logic [31:0] pw_q;
    logic        le_q;
    logic [31:0] pend_q, pend_nxt;
    logic [3:0]  wait_q, wait_nxt;
    logic [4:0]  wait_inc;

    logic        wb_win, mc_win, refused, reserve, stall;
    logic [4:0]  win_rd;
    logic [31:0] win_data;

    assign wb_win   = bus.wb_valid;
    assign mc_win   = bus.mc_valid & ~bus.wb_valid;
    assign refused  = bus.mc_valid & bus.wb_valid;
    assign win_rd   = wb_win ? bus.wb_rd   : bus.mc_rd;
    assign win_data = wb_win ? bus.wb_data : bus.mc_data;

    // Checked against the current scoreboard: a register retiring this cycle still stalls.
    assign stall = bus.iss_valid &
                   ((bus.iss_ra_use & pend_q[bus.iss_ra]) |
                    (bus.iss_rb_use & pend_q[bus.iss_rb]) |
                    (bus.iss_rd_use & pend_q[bus.iss_rd]));

    assign reserve = bus.iss_valid & bus.iss_long & bus.iss_rd_use & ~stall &
                     (bus.iss_rd != 5'd0);

    assign bus.mc_ready    = mc_win;
    assign bus.issue_stall = stall;
    assign bus.pipe_stall  = (state_q == FORCE);
    assign bus.RW          = rw_q;
    assign bus.PW          = pw_q;
    assign bus.LE          = le_q;
    assign bus.pend        = pend_q;

    always_comb begin
        pend_nxt = pend_q;
        if (mc_win)  pend_nxt[bus.mc_rd]  = 1'b0;
        if (reserve) pend_nxt[bus.iss_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_comb begin
        wait_inc = {1'b0, wait_q} + 5'd1;
        if (!refused)              wait_nxt = '0;
        else if (wait_q == 4'hf)   wait_nxt = wait_q;
        else                       wait_nxt = wait_inc[3:0];
    end

    // FORCE is left once the multi-cycle request is either granted or withdrawn.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ARB:     if (refused && wait_inc >= LIMIT) state_nxt = FORCE;
            FORCE:   if (!refused)                     state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            wait_q  <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_nxt;
            wait_q  <= wait_nxt;
            pend_q  <= pend_nxt;
        end
    end

    // R0 writes are accepted by the handshake but leave the port outputs untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q <= '0;
            pw_q <= '0;
            le_q <= 1'b0;
        end else if ((wb_win | mc_win) && win_rd != 5'd0) begin
            rw_q <= win_rd;
            pw_q <= win_data;
            le_q <= 1'b1;
        end else begin
            le_q <= 1'b0;
        end
    end

`ifdef RF_ARB_PERF_EN
    localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            conflict_cnt <= '0;
        else if (refused && conflict_cnt != '1)
            conflict_cnt <= conflict_cnt + PERF_ONE;
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table, async reset sequence,
// then randomized traffic against a behavioural model.
module tb_rf_write_arbiter;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rf_write_arbiter_if bus ();
`ifdef RF_ARB_PERF_EN
    logic [15:0] conflict_cnt;
`endif

    rf_write_arbiter #(.STARVE_LIMIT(LIMIT), .PERF_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef RF_ARB_PERF_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit wbv, input bit [4:0] wbrd, input bit [31:0] wbd,
                         input bit mcv, input bit [4:0] mcrd, input bit [31:0] mcd,
                         input bit isv, input bit [4:0] ra, input bit rau,
                         input bit [4:0] rb, input bit rbu,
                         input bit [4:0] rd, input bit rdu, input bit lng);
        bus.wb_valid = wbv;  bus.wb_rd = wbrd;  bus.wb_data = wbd;
        bus.mc_valid = mcv;  bus.mc_rd = mcrd;  bus.mc_data = mcd;
        bus.iss_valid = isv; bus.iss_long = lng;
        bus.iss_ra = ra; bus.iss_ra_use = rau;
        bus.iss_rb = rb; bus.iss_rb_use = rbu;
        bus.iss_rd = rd; bus.iss_rd_use = rdu;
    endtask

    typedef struct {
        bit wbv; bit [4:0] wbrd; bit [31:0] wbd;
        bit mcv; bit [4:0] mcrd; bit [31:0] mcd;
        bit isv; bit [4:0] ra; bit rau; bit [4:0] rd; bit rdu; bit lng;
        bit e_rdy; bit e_stall;
        bit [4:0] e_rw; bit [31:0] e_pw; bit e_le; bit [31:0] e_pend; bit e_ps;
    } vec_t;

    vec_t tbl [17];

    // Behavioural reference state
    bit [31:0] m_pend;
    bit [4:0]  m_rw;
    bit [31:0] m_pw;
    bit        m_le;
    int        m_wait;
    bit        m_force;

    task automatic model_reset();
        m_pend = '0; m_rw = '0; m_pw = '0; m_le = 1'b0; m_wait = 0; m_force = 1'b0;
    endtask

    function automatic bit model_stall();
        return bus.iss_valid && ((bus.iss_ra_use && m_pend[bus.iss_ra]) ||
                                 (bus.iss_rb_use && m_pend[bus.iss_rb]) ||
                                 (bus.iss_rd_use && m_pend[bus.iss_rd]));
    endfunction

    task automatic model_edge();
        bit st, refused;
        bit [4:0] rd;
        bit [31:0] d;
        bit any;
        st = model_stall();
        refused = bus.mc_valid && bus.wb_valid;
        any = 1'b1;
        if (bus.wb_valid)      begin rd = bus.wb_rd; d = bus.wb_data; end
        else if (bus.mc_valid) begin rd = bus.mc_rd; d = bus.mc_data; m_pend[bus.mc_rd] = 1'b0; end
        else begin rd = 0; d = 0; any = 1'b0; end
        if (any && rd != 0) begin m_rw = rd; m_pw = d; m_le = 1'b1; end
        else m_le = 1'b0;
        if (bus.iss_valid && bus.iss_long && bus.iss_rd_use && !st && bus.iss_rd != 0)
            m_pend[bus.iss_rd] = 1'b1;
        m_pend[0] = 1'b0;
        m_wait = refused ? ((m_wait + 1 > 15) ? 15 : m_wait + 1) : 0;
        if (!m_force) m_force = refused && (m_wait >= LIMIT);
        else if (!refused) m_force = 1'b0;
    endtask

    function automatic bit [4:0] pick_pending(input bit [4:0] fallback);
        int start = $urandom_range(0, 31);
        for (int k = 0; k < 32; k++) begin
            int idx = (start + k) % 32;
            if (m_pend[idx]) return 5'(idx);
        end
        return fallback;
    endfunction

    initial begin
        bit        mcp;
        bit [4:0]  mrd, ra, rb, rd;
        bit [31:0] mdat;
        bit        wbv, lng;

        //           wbv rd d     mcv rd d     isv ra u rd u l  rdy st  rw pw  le pend    ps
        tbl[0]  = '{1, 5, 20,   0, 0, 0,    0, 0, 0, 0, 0, 0,  0, 0,  5, 20, 1, 0,      0};
        tbl[1]  = '{1, 0, 7,    0, 0, 0,    0, 0, 0, 0, 0, 0,  0, 0,  5, 20, 0, 0,      0};
        tbl[2]  = '{1, 3, 33,   1, 9, 99,   0, 0, 0, 0, 0, 0,  0, 0,  3, 33, 1, 0,      0};
        tbl[3]  = '{0, 0, 0,    1, 9, 99,   0, 0, 0, 0, 0, 0,  1, 0,  9, 99, 1, 0,      0};
        tbl[4]  = '{0, 0, 0,    0, 0, 0,    1, 0, 0, 7, 1, 1,  0, 0,  9, 99, 0, 'h80,   0};
        tbl[5]  = '{0, 0, 0,    0, 0, 0,    1, 7, 1, 0, 0, 0,  0, 1,  9, 99, 0, 'h80,   0};
        tbl[6]  = '{0, 0, 0,    1, 7, 77,   1, 7, 1, 0, 0, 0,  1, 1,  7, 77, 1, 0,      0};
        tbl[7]  = '{0, 0, 0,    0, 0, 0,    1, 7, 1, 0, 0, 0,  0, 0,  7, 77, 0, 0,      0};
        tbl[8]  = '{0, 0, 0,    0, 0, 0,    1, 0, 0, 0, 1, 1,  0, 0,  7, 77, 0, 0,      0};
        tbl[9]  = '{0, 0, 0,    0, 0, 0,    1, 0, 1, 0, 0, 0,  0, 0,  7, 77, 0, 0,      0};
        tbl[10] = '{1, 1, 1,    1, 2, 2,    0, 0, 0, 0, 0, 0,  0, 0,  1, 1,  1, 0,      0};
        tbl[11] = '{1, 1, 2,    1, 2, 2,    0, 0, 0, 0, 0, 0,  0, 0,  1, 2,  1, 0,      0};
        tbl[12] = '{1, 1, 3,    1, 2, 2,    0, 0, 0, 0, 0, 0,  0, 0,  1, 3,  1, 0,      0};
        tbl[13] = '{1, 1, 4,    1, 2, 2,    0, 0, 0, 0, 0, 0,  0, 0,  1, 4,  1, 0,      1};
        tbl[14] = '{1, 1, 5,    1, 2, 2,    0, 0, 0, 0, 0, 0,  0, 0,  1, 5,  1, 0,      1};
        tbl[15] = '{0, 0, 0,    1, 2, 2,    0, 0, 0, 0, 0, 0,  1, 0,  2, 2,  1, 0,      0};
        tbl[16] = '{0, 0, 0,    1, 0, 9,    0, 0, 0, 0, 0, 0,  1, 0,  2, 2,  0, 0,      0};

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("reset RW", 32'(bus.RW), 0);
        chk("reset PW", bus.PW, 0);
        chk("reset LE", 32'(bus.LE), 0);
        chk("reset pend", bus.pend, 0);
        chk("reset pipe_stall", 32'(bus.pipe_stall), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].wbv, tbl[i].wbrd, tbl[i].wbd, tbl[i].mcv, tbl[i].mcrd, tbl[i].mcd,
                  tbl[i].isv, tbl[i].ra, tbl[i].rau, 5'd0, 1'b0, tbl[i].rd, tbl[i].rdu, tbl[i].lng);
            #1;
            chk($sformatf("tbl%0d mc_ready", i), 32'(bus.mc_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d issue_stall", i), 32'(bus.issue_stall), 32'(tbl[i].e_stall));
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d RW", i), 32'(bus.RW), 32'(tbl[i].e_rw));
            chk($sformatf("tbl%0d PW", i), bus.PW, tbl[i].e_pw);
            chk($sformatf("tbl%0d LE", i), 32'(bus.LE), 32'(tbl[i].e_le));
            chk($sformatf("tbl%0d pend", i), bus.pend, tbl[i].e_pend);
            chk($sformatf("tbl%0d pipe_stall", i), 32'(bus.pipe_stall), 32'(tbl[i].e_ps));
        end

        // Reserve R12 while WB writes R4, then pull reset mid-cycle.
        drive(1, 4, 44, 0, 0, 0, 1, 0, 0, 0, 0, 12, 1, 1);
        @(posedge clk);
        @(negedge clk);
        chk("pre-reset LE", 32'(bus.LE), 1);
        chk("pre-reset pend", bus.pend, 32'h0000_1000);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("pre-reset LE held", 32'(bus.LE), 0);
        drive(1, 6, 66, 0, 0, 0, 1, 0, 0, 0, 0, 12, 0, 0);
        @(negedge clk);
        // Re-arm LE and pend[12] so the async reset has something to clear.
        drive(1, 6, 66, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("mid LE", 32'(bus.LE), 1);
        rst_n = 1'b0;
        #1;
        chk("async LE", 32'(bus.LE), 0);
        chk("async pend", bus.pend, 0);
        chk("async pipe_stall", 32'(bus.pipe_stall), 0);
        chk("async RW", 32'(bus.RW), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        mcp = 1'b0; mrd = '0; mdat = '0;
        for (int c = 0; c < 800; c++) begin
            if (!mcp && $urandom_range(0, 2) == 0) begin
                mcp  = 1'b1;
                mrd  = pick_pending(5'($urandom_range(0, 31)));
                mdat = $urandom;
            end
            wbv = m_force ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 6);
            ra  = $urandom_range(0, 1) ? pick_pending(5'($urandom_range(0, 31))) : 5'($urandom_range(0, 31));
            rb  = 5'($urandom_range(0, 31));
            rd  = 5'($urandom_range(0, 31));
            lng = ($urandom_range(0, 2) == 0);
            if (mcp && rd == mrd) lng = 1'b0;
            drive(wbv, 5'($urandom_range(0, 31)), $urandom, mcp, mrd, mdat,
                  1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)),
                  rb, 1'($urandom_range(0, 1)), rd, 1'($urandom_range(0, 1)), lng);
            #1;
            chk("rnd mc_ready", 32'(bus.mc_ready), 32'(mcp && !wbv));
            chk("rnd issue_stall", 32'(bus.issue_stall), 32'(model_stall()));
            model_edge();
            if (mcp && !wbv) mcp = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("rnd RW", 32'(bus.RW), 32'(m_rw));
            chk("rnd PW", bus.PW, m_pw);
            chk("rnd LE", 32'(bus.LE), 32'(m_le));
            chk("rnd pend", bus.pend, m_pend);
            chk("rnd pipe_stall", 32'(bus.pipe_stall), 32'(m_force));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
